// File: rtl/stat_pkg.sv
// rtl/stat_pkg.sv - shared types and helpers for the statistics counter bank
package stat_pkg;

    typedef enum logic {
        LIVE   = 1'b0,
        FROZEN = 1'b1
    } read_mode_t;

    localparam int SHOW_CODE_DEFAULT = 34;

    // Select width never collapses to zero so a single-channel bank still has a port.
    function automatic int sel_width(input int num_evt);
        return (num_evt > 1) ? $clog2(num_evt) : 1;
    endfunction

endpackage

// File: rtl/stat_counter.sv
// rtl/stat_counter.sv - one event channel: counter with wrap/saturate and sticky overflow
module stat_counter #(
    parameter int CNT_W = 32,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic at_max;

    assign at_max = &cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc) begin
            if (at_max) begin
                ovf <= 1'b1;
                // Saturating channels simply hold all-ones.
                if (SAT == 0) begin
                    cnt <= '0;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stat_counter_bank.sv
// rtl/stat_counter_bank.sv - event counter bank with snapshot read mode and syscall display latch
module stat_counter_bank
    import stat_pkg::*;
#(
    parameter int  NUM_EVT   = 4,
    parameter int  CNT_W     = 32,
    parameter int  SAT       = 0,
    parameter int  SHOW_CODE = SHOW_CODE_DEFAULT,
    localparam int SEL_W     = sel_width(NUM_EVT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               clr,
    input  logic               freeze,
    input  logic [SEL_W-1:0]   sel,
    output logic [CNT_W-1:0]   rd_data,
    output logic [NUM_EVT-1:0] ovf,
    output logic               frozen,
    input  logic               sys_req,
    input  logic [31:0]        sys_code,
    input  logic [31:0]        sys_val,
    output logic [31:0]        show_val,
    output logic               show_vld
);

    logic [CNT_W-1:0] cnt    [NUM_EVT];
    logic [CNT_W-1:0] shadow [NUM_EVT];
    logic [CNT_W-1:0] rd_next;
    read_mode_t       state_q;
    read_mode_t       state_d;
    logic             capture;

    for (genvar i = 0; i < NUM_EVT; i++) begin : g_chan
        stat_counter #(
            .CNT_W (CNT_W),
            .SAT   (SAT)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (run & evt[i] & ~clr),
            .clr (clr),
            .cnt (cnt[i]),
            .ovf (ovf[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LIVE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            LIVE: begin
                if (freeze) begin
                    state_d = FROZEN;
                    capture = 1'b1;
                end
            end
            FROZEN: begin
                if (freeze) begin
                    state_d = LIVE;
                end
            end
            default: state_d = LIVE;
        endcase
    end

    assign frozen = (state_q == FROZEN);

    // Capture samples the counters before any same-edge clear takes effect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_EVT; i++) begin
                shadow[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_EVT; i++) begin
                shadow[i] <= cnt[i];
            end
        end
    end

    // Compare against each channel rather than indexing so out-of-range selects read zero.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_EVT; i++) begin
            if (sel == SEL_W'(i)) begin
                rd_next = frozen ? shadow[i] : cnt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            show_val <= '0;
            show_vld <= 1'b0;
        end else begin
            show_vld <= 1'b0;
            if (sys_req && (sys_code == 32'(SHOW_CODE))) begin
                show_val <= sys_val;
                show_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stat_counter_bank.sv
// tb/tb_stat_counter_bank.sv - directed self-checking bench for stat_counter_bank
module tb_stat_counter_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [3:0]  evt;
    logic        clr;
    logic        freeze;
    logic [1:0]  sel;
    logic        sys_req;
    logic [31:0] sys_code;
    logic [31:0] sys_val;

    logic [7:0]  rd_data;
    logic [3:0]  ovf;
    logic        frozen;
    logic [31:0] show_val;
    logic        show_vld;

    logic [7:0]  rd_data_s;
    logic [2:0]  ovf_s;
    logic        frozen_s;
    logic [31:0] show_val_s;
    logic        show_vld_s;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    stat_counter_bank #(
        .NUM_EVT   (4),
        .CNT_W     (8),
        .SAT       (0),
        .SHOW_CODE (34)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .evt      (evt),
        .clr      (clr),
        .freeze   (freeze),
        .sel      (sel),
        .rd_data  (rd_data),
        .ovf      (ovf),
        .frozen   (frozen),
        .sys_req  (sys_req),
        .sys_code (sys_code),
        .sys_val  (sys_val),
        .show_val (show_val),
        .show_vld (show_vld)
    );

    stat_counter_bank #(
        .NUM_EVT   (3),
        .CNT_W     (8),
        .SAT       (1),
        .SHOW_CODE (34)
    ) dut_sat (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .evt      (evt[2:0]),
        .clr      (clr),
        .freeze   (freeze),
        .sel      (sel),
        .rd_data  (rd_data_s),
        .ovf      (ovf_s),
        .frozen   (frozen_s),
        .sys_req  (sys_req),
        .sys_code (sys_code),
        .sys_val  (sys_val),
        .show_val (show_val_s),
        .show_vld (show_vld_s)
    );

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
    endtask

    task automatic count_evt(input logic [3:0] pattern, input int n);
        evt = pattern;
        cycles(n);
        evt = 4'b0000;
    endtask

    task automatic test_reset();
        tests++;
        if (rd_data !== 8'd0 || ovf !== 4'd0 || frozen !== 1'b0 || show_val !== 32'd0 || show_vld !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: rd=%0d ovf=%b frozen=%b show_val=%h show_vld=%b, required all zero",
                     rd_data, ovf, frozen, show_val, show_vld);
        end
        tests++;
        if (rd_data_s !== 8'd0 || ovf_s !== 3'd0 || frozen_s !== 1'b0) begin
            fails++;
            $display("FAIL reset_sat_outputs: rd=%0d ovf=%b frozen=%b, required all zero", rd_data_s, ovf_s, frozen_s);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_count();
        logic [7:0] exp_rd [4] = '{8'd10, 8'd10, 8'd0, 8'd0};
        run = 1'b1;
        count_evt(4'b0011, 10);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            cycles(2);
            tests++;
            if (rd_data !== exp_rd[s]) begin
                fails++;
                $display("FAIL count_sel%0d: rd_data=%0d, required %0d", s, rd_data, exp_rd[s]);
            end
        end
        tests++;
        if (rd_data_s !== 8'd0) begin
            fails++;
            $display("FAIL sel_out_of_range: rd_data=%0d, required 0", rd_data_s);
        end
    endtask

    task automatic test_latency();
        sel = 2'd0;
        pulse_clr();
        cycles(2);
        evt = 4'b0001;
        cycles(1);
        evt = 4'b0000;
        tests++;
        if (rd_data !== 8'd0) begin
            fails++;
            $display("FAIL rd_latency_early: rd_data=%0d, required 0", rd_data);
        end
        cycles(1);
        tests++;
        if (rd_data !== 8'd1) begin
            fails++;
            $display("FAIL rd_latency_late: rd_data=%0d, required 1", rd_data);
        end
    endtask

    task automatic test_gating_clear();
        pulse_clr();
        count_evt(4'b0001, 4);
        run = 1'b0;
        count_evt(4'b1111, 5);
        run = 1'b1;
        sel = 2'd0;
        cycles(2);
        tests++;
        if (rd_data !== 8'd4) begin
            fails++;
            $display("FAIL run_gating: rd_data=%0d, required 4", rd_data);
        end
        evt = 4'b0001;
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        evt = 4'b0000;
        cycles(2);
        tests++;
        if (rd_data !== 8'd0 || ovf !== 4'd0) begin
            fails++;
            $display("FAIL clr_over_inc: rd_data=%0d ovf=%b, required 0 and 0000", rd_data, ovf);
        end
    endtask

    task automatic test_overflow();
        pulse_clr();
        sel = 2'd0;
        count_evt(4'b0001, 257);
        cycles(2);
        tests++;
        if (rd_data !== 8'd1 || ovf !== 4'b0001) begin
            fails++;
            $display("FAIL wrap_257: rd_data=%0d ovf=%b, required 1 and 0001", rd_data, ovf);
        end
        count_evt(4'b0001, 43);
        cycles(2);
        tests++;
        if (rd_data !== 8'd44 || ovf !== 4'b0001) begin
            fails++;
            $display("FAIL wrap_300_sticky: rd_data=%0d ovf=%b, required 44 and 0001", rd_data, ovf);
        end
        tests++;
        if (rd_data_s !== 8'd255 || ovf_s !== 3'b001) begin
            fails++;
            $display("FAIL sat_300: rd_data=%0d ovf=%b, required 255 and 001", rd_data_s, ovf_s);
        end
        pulse_clr();
        cycles(2);
        tests++;
        if (ovf !== 4'd0 || ovf_s !== 3'd0 || rd_data !== 8'd0 || rd_data_s !== 8'd0) begin
            fails++;
            $display("FAIL ovf_clear: ovf=%b ovf_s=%b rd=%0d rd_s=%0d, required all zero", ovf, ovf_s, rd_data, rd_data_s);
        end
    endtask

    task automatic test_freeze();
        pulse_clr();
        sel = 2'd0;
        count_evt(4'b0001, 20);
        freeze = 1'b1;
        cycles(1);
        freeze = 1'b0;
        count_evt(4'b0001, 7);
        cycles(2);
        tests++;
        if (rd_data !== 8'd20 || frozen !== 1'b1) begin
            fails++;
            $display("FAIL freeze_shadow: rd_data=%0d frozen=%b, required 20 and 1", rd_data, frozen);
        end
        freeze = 1'b1;
        cycles(1);
        freeze = 1'b0;
        cycles(2);
        tests++;
        if (rd_data !== 8'd27 || frozen !== 1'b0) begin
            fails++;
            $display("FAIL unfreeze_live: rd_data=%0d frozen=%b, required 27 and 0", rd_data, frozen);
        end
        pulse_clr();
        count_evt(4'b0001, 20);
        freeze = 1'b1;
        clr = 1'b1;
        cycles(1);
        freeze = 1'b0;
        clr = 1'b0;
        cycles(2);
        tests++;
        if (rd_data !== 8'd20 || frozen !== 1'b1) begin
            fails++;
            $display("FAIL freeze_clr_shadow: rd_data=%0d frozen=%b, required 20 and 1", rd_data, frozen);
        end
        freeze = 1'b1;
        cycles(1);
        freeze = 1'b0;
        cycles(2);
        tests++;
        if (rd_data !== 8'd0 || frozen !== 1'b0) begin
            fails++;
            $display("FAIL freeze_clr_live: rd_data=%0d frozen=%b, required 0 and 0", rd_data, frozen);
        end
    endtask

    task automatic test_syscall();
        sys_req  = 1'b1;
        sys_code = 32'd34;
        sys_val  = 32'hDEADBEEF;
        cycles(1);
        sys_req  = 1'b0;
        tests++;
        if (show_val !== 32'hDEADBEEF || show_vld !== 1'b1) begin
            fails++;
            $display("FAIL show_update: show_val=%h show_vld=%b, required deadbeef and 1", show_val, show_vld);
        end
        cycles(1);
        tests++;
        if (show_vld !== 1'b0 || show_val !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL show_pulse_width: show_val=%h show_vld=%b, required deadbeef and 0", show_val, show_vld);
        end
        sys_req  = 1'b1;
        sys_code = 32'd10;
        sys_val  = 32'h00001234;
        cycles(1);
        sys_req  = 1'b0;
        tests++;
        if (show_vld !== 1'b0 || show_val !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL show_wrong_code: show_val=%h show_vld=%b, required deadbeef and 0", show_val, show_vld);
        end
        run      = 1'b0;
        clr      = 1'b1;
        sys_req  = 1'b1;
        sys_code = 32'd34;
        sys_val  = 32'h00000001;
        cycles(1);
        sys_val  = 32'h00000002;
        tests++;
        if (show_vld !== 1'b1 || show_val !== 32'h00000001) begin
            fails++;
            $display("FAIL show_b2b_first: show_val=%h show_vld=%b, required 00000001 and 1", show_val, show_vld);
        end
        cycles(1);
        sys_req  = 1'b0;
        clr      = 1'b0;
        run      = 1'b1;
        tests++;
        if (show_vld !== 1'b1 || show_val !== 32'h00000002) begin
            fails++;
            $display("FAIL show_b2b_second: show_val=%h show_vld=%b, required 00000002 and 1", show_val, show_vld);
        end
    endtask

    task automatic test_mid_reset();
        pulse_clr();
        sel = 2'd1;
        count_evt(4'b0011, 9);
        sys_req  = 1'b1;
        sys_code = 32'd34;
        sys_val  = 32'hCAFE0001;
        freeze   = 1'b1;
        cycles(1);
        sys_req  = 1'b0;
        freeze   = 1'b0;
        cycles(2);
        tests++;
        if (rd_data !== 8'd9 || frozen !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_frozen: rd_data=%0d frozen=%b, required 9 and 1", rd_data, frozen);
        end
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (rd_data !== 8'd0 || ovf !== 4'd0 || frozen !== 1'b0 || show_val !== 32'd0 || show_vld !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: rd=%0d ovf=%b frozen=%b show_val=%h show_vld=%b, required all zero",
                     rd_data, ovf, frozen, show_val, show_vld);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        freeze = 1'b1;
        cycles(1);
        freeze = 1'b0;
        cycles(2);
        tests++;
        if (rd_data !== 8'd0 || frozen !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_live: rd_data=%0d frozen=%b, required 0 and 1", rd_data, frozen);
        end
    endtask

    initial begin
        rst      = 1'b0;
        run      = 1'b0;
        evt      = 4'b0000;
        clr      = 1'b0;
        freeze   = 1'b0;
        sel      = 2'd0;
        sys_req  = 1'b0;
        sys_code = 32'd0;
        sys_val  = 32'd0;
        #12;
        test_reset();
        test_count();
        test_latency();
        test_gating_clear();
        test_overflow();
        test_freeze();
        test_syscall();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stat_counter_bank.md
# stat_counter_bank

Parametrised performance-statistics block for the 5-stage MIPS core. It keeps NUM_EVT independent event counters gated by the core's run qualifier, with selectable wrap or saturate behaviour and sticky overflow flags. A snapshot/freeze mode lets software or the debug display read a coherent set of values while counting continues. It also includes the syscall display latch, and it replaces the fixed four-counter statistics unit next to the writeback stage.

## Interface
Parameters:
- NUM_EVT, 4: number of event channels. Range 1..16.
- CNT_W, 32: counter width in bits. Range 8..64.
- SAT, 0: 0 = counters wrap, 1 = counters saturate at all-ones.
- SHOW_CODE, 34: syscall code that updates the display value.

Ports (SEL_W = max(1, $clog2(NUM_EVT))):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  counting qualifier; the core is not halted.
- evt  in  NUM_EVT  per-channel event strobes. evt[0] is tied high at top level to count cycles.
- clr  in  1  synchronous clear of all counters and ovf.
- freeze  in  1  single-cycle pulse that toggles the LIVE/FROZEN read mode.
- sel  in  SEL_W  read channel select.
- rd_data  out  CNT_W  registered read value.
- ovf  out  NUM_EVT  sticky overflow flags.
- frozen  out  1  high while in FROZEN.
- sys_req  in  1  syscall retiring this cycle.
- sys_code  in  32  syscall code ($v0).
- sys_val  in  32  syscall argument ($a0).
- show_val  out  32  latched display value.
- show_vld  out  1  one-cycle pulse when show_val updates.

## Operation
Counters:
- Counter i increments when run & evt[i] & !clr.
- When clr is high, every counter and every ovf bit goes to 0. clr overrides increments in the same cycle.
- Wrap mode (SAT=0): an increment from all-ones gives 0 and sets ovf[i].
- Saturate mode (SAT=1): an increment attempted at all-ones holds the value and sets ovf[i].
- ovf bits are sticky. Only clr or rst clears them.

Read mode FSM (states LIVE, FROZEN):
- LIVE → FROZEN on freeze. The same edge copies all live counters into the shadow registers.
- FROZEN → LIVE on freeze.
- In LIVE, rd_data reads live counter[sel]. In FROZEN, it reads shadow[sel].
- Counters keep running in FROZEN. clr does not alter the shadow registers.
- If freeze and clr are in the same cycle, the shadow captures the pre-clear values.
- If sel ≥ NUM_EVT, rd_data is 0.

Syscall display:
- When sys_req and sys_code == SHOW_CODE, show_val ← sys_val and show_vld pulses for one cycle.
- The display path is independent of run and clr.

## Timing
- Reset: all counters, shadows, ovf, rd_data, show_val, and show_vld are 0. State is LIVE and frozen is 0. Reset takes effect immediately with no clock and releases synchronously into LIVE.
- Counter update: the value is visible internally one edge after the qualifying cycle.
- rd_data latency:
  - Registered, one cycle after sel or the source value changes.
  - An event at edge k appears in LIVE rd_data after edge k+1.
  - After an LIVE→FROZEN transition, rd_data shows the shadow at the next edge.
- show_val/show_vld: update on the edge after sys_req. Back-to-back requests give back-to-back pulses.
- Reset asserted mid-snapshot: the block returns to LIVE with zeroed shadows.
- freeze held high for multiple cycles toggles the state every cycle. Drivers must pulse it.

## Structure
- Package stat_pkg:
  - read_mode_t enum {LIVE, FROZEN}.
  - SHOW_CODE_DEFAULT = 34.
  - SEL_W helper function.
- Sub-module stat_counter (params CNT_W, SAT; ports clk, rst, inc, clr, cnt, ovf) holds one channel's counter and overflow logic. It is instantiated NUM_EVT times in a generate loop.
- The top level holds the FSM, shadow array, read mux, and syscall latch.

## Test plan
- Reset/count: rst low then released, run=1, evt=4'b0011 for 10 cycles, sel=0 then 1 → rd_data reads 10 for both; channels 2 and 3 read 0.
- Gating and clear: run=0 for 5 cycles with events → no change. clr together with evt[0] → counter 0, and ovf stays 0.
- Overflow, CNT_W=8:
  - SAT=0: 257 events give 1 with ovf[0]=1.
  - SAT=1: 300 events give 255 with ovf[0]=1.
  - ovf stays set until clr.
- Freeze:
  - Counter at 20, freeze pulse, 7 more events → rd_data=20 and frozen=1.
  - Second freeze → rd_data=27.
  - freeze together with clr → shadow 20, live 0.
- Syscall: sys_req with code 34 and val 0xDEADBEEF → show_val=0xDEADBEEF with a 1-cycle show_vld. Code 10 → no update.
- Mid-operation reset: async rst asserted while FROZEN with nonzero counters → all outputs 0 immediately and state LIVE.
